// File: rtl/f32_pkg.sv
// Shared types and constants for the sequential binary32 add/sub unit.
package f32_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } f32_t;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  // Significand with hidden bit; exponent 0 (zero/denormal) flushes to 0.
  function automatic logic [23:0] mant(input f32_t f);
    return (f.exp == 8'd0) ? 24'd0 : {1'b1, f.frac};
  endfunction
endpackage

// File: rtl/f32_lzc.sv
// Combinational 28-bit leading-zero counter; all-zero input yields 28.
module f32_lzc (
  input  logic [27:0] i_v,
  output logic [4:0]  o_cnt
);
  always_comb begin
    o_cnt = 5'd28;
    for (int i = 0; i < 28; i++)
      if (i_v[i]) o_cnt = 5'(27 - i);
  end
endmodule

// File: rtl/f32_seq_addsub.sv
// Iterative binary32 adder/subtractor: one state per pipeline step, DONE six cycles after START.
module f32_seq_addsub
  import f32_pkg::*;
#(
  parameter bit          ROUND_RNE = 1'b1,
  parameter logic [31:0] QNAN      = 32'h7FC0_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        OP,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] R,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
);
  state_t r_state, w_next;
  f32_t   r_a, r_b;
  logic   r_op;
  logic   r_sx, r_sy, r_spec, r_zero;
  logic [31:0] r_spec_val;
  logic signed [9:0] r_ex, r_ne;
  logic [7:0]  r_ey;
  logic [23:0] r_mx, r_my;
  logic [26:0] r_fx, r_fy, r_nm;
  logic [27:0] r_sum;
  logic [31:0] r_r;
  logic r_done, r_ovf, r_unf;

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (START) w_next = UNPACK;
      UNPACK:  w_next = ALIGN;
      ALIGN:   w_next = ADD;
      ADD:     w_next = NORM;
      NORM:    w_next = ROUND;
      ROUND:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // UNPACK: effective sign of B, magnitude ordering, special-case result.
  logic w_bs, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
  f32_t w_beff, w_x, w_y;
  logic [31:0] w_spec_val;
  always_comb begin
    w_bs    = r_b.sign ^ r_op;
    w_beff  = '{sign: w_bs, exp: r_b.exp, frac: r_b.frac};
    w_a_nan = (r_a.exp == EXP_MAX) && (r_a.frac != 23'd0);
    w_b_nan = (r_b.exp == EXP_MAX) && (r_b.frac != 23'd0);
    w_a_inf = (r_a.exp == EXP_MAX) && (r_a.frac == 23'd0);
    w_b_inf = (r_b.exp == EXP_MAX) && (r_b.frac == 23'd0);
    w_swap  = ((r_b.exp == 8'd0) ? 31'd0 : {r_b.exp, r_b.frac}) >
              ((r_a.exp == 8'd0) ? 31'd0 : {r_a.exp, r_a.frac});
    w_x     = w_swap ? w_beff : r_a;
    w_y     = w_swap ? r_a : w_beff;
    w_spec_val = QNAN;
    if (w_a_nan || w_b_nan)                       w_spec_val = QNAN;
    else if (w_a_inf && w_b_inf && (r_a.sign != w_bs)) w_spec_val = QNAN;
    else if (w_a_inf)                             w_spec_val = {r_a.sign, POS_INF[30:0]};
    else if (w_b_inf)                             w_spec_val = {w_bs, POS_INF[30:0]};
  end

  // ALIGN: right-shift Y into {1.frac,G,R,S}, folding lost bits into S.
  logic [7:0]  w_d;
  logic [4:0]  w_sh;
  logic [26:0] w_yf, w_ysh, w_mask;
  always_comb begin
    w_d    = r_ex[7:0] - r_ey;
    w_sh   = (w_d >= 8'd27) ? 5'd27 : w_d[4:0];
    w_yf   = {r_my, 3'b000};
    w_ysh  = w_yf >> w_sh;
    w_mask = ~(27'h7FF_FFFF << w_sh);
  end

  logic [4:0] w_lzc, w_lsh;
  f32_lzc u_lzc (.i_v(r_sum), .o_cnt(w_lzc));
  assign w_lsh = w_lzc - 5'd1;

  // ROUND: RNE on G&(R|S|lsb), then range checks on the widened exponent.
  logic        w_inc, w_ovf, w_unf;
  logic [24:0] w_m25;
  logic signed [9:0] w_re;
  logic [22:0] w_frac;
  logic [31:0] w_res;
  always_comb begin
    w_inc  = ROUND_RNE & r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
    w_m25  = {1'b0, r_nm[26:3]} + {24'd0, w_inc};
    w_re   = r_ne + $signed({9'd0, w_m25[24]});
    w_frac = w_m25[24] ? w_m25[23:1] : w_m25[22:0];
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_res  = {r_sx, w_re[7:0], w_frac};
    if (r_spec) begin
      w_res = r_spec_val;
    end else if (r_zero) begin
      w_res = {r_sx & r_sy, 31'd0};
    end else if (w_re >= $signed({2'b00, EXP_MAX})) begin
      w_res = {r_sx, EXP_MAX, 23'd0};
      w_ovf = 1'b1;
    end else if (w_re <= 10'sd0) begin
      w_res = {r_sx, 31'd0};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_a <= '0; r_b <= '0; r_op <= 1'b0;
      r_sx <= 1'b0; r_sy <= 1'b0; r_spec <= 1'b0; r_zero <= 1'b0;
      r_spec_val <= '0; r_ex <= '0; r_ne <= '0; r_ey <= '0;
      r_mx <= '0; r_my <= '0; r_fx <= '0; r_fy <= '0; r_nm <= '0; r_sum <= '0;
      r_r <= '0; r_done <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0;
    end else begin
      r_done <= (r_state == ROUND);
      case (r_state)
        IDLE: if (START) begin
          r_a <= A; r_b <= B; r_op <= OP;
        end
        UNPACK: begin
          r_sx <= w_x.sign; r_sy <= w_y.sign;
          r_ex <= $signed({2'b00, w_x.exp}); r_ey <= w_y.exp;
          r_mx <= mant(w_x); r_my <= mant(w_y);
          r_spec <= w_a_nan | w_b_nan | w_a_inf | w_b_inf;
          r_spec_val <= w_spec_val;
        end
        ALIGN: begin
          r_fx <= {r_mx, 3'b000};
          r_fy <= {w_ysh[26:1], w_ysh[0] | (|(w_yf & w_mask))};
        end
        ADD: r_sum <= (r_sx == r_sy) ? {1'b0, r_fx} + {1'b0, r_fy}
                                     : {1'b0, r_fx} - {1'b0, r_fy};
        NORM: begin
          r_zero <= (r_sum == 28'd0);
          if (r_sum[27]) begin
            r_nm <= {r_sum[27:2], |r_sum[1:0]};
            r_ne <= r_ex + 10'sd1;
          end else begin
            r_nm <= r_sum[26:0] << w_lsh;
            r_ne <= r_ex - $signed({5'd0, w_lsh});
          end
        end
        ROUND: begin
          r_r <= w_res; r_ovf <= w_ovf; r_unf <= w_unf;
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (r_state != IDLE);
  assign DONE      = r_done;
  assign R         = r_r;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_unf;
endmodule

// File: tb/tb_f32_seq_addsub.sv
// Scoreboard bench for f32_seq_addsub: RNE instance plus a truncating instance on the same stimulus.
module tb_f32_seq_addsub;
  logic        CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, OP = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        BUSY, DONE, OVERFLOW, UNDERFLOW;
  logic [31:0] R;
  logic        BUSY_t, DONE_t, OVERFLOW_t, UNDERFLOW_t;
  logic [31:0] R_t;

  f32_seq_addsub u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .A(A), .B(B), .OP(OP),
    .BUSY(BUSY), .DONE(DONE), .R(R), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW));

  f32_seq_addsub #(.ROUND_RNE(1'b0)) u_trunc (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .A(A), .B(B), .OP(OP),
    .BUSY(BUSY_t), .DONE(DONE_t), .R(R_t), .OVERFLOW(OVERFLOW_t), .UNDERFLOW(UNDERFLOW_t));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] r;
    logic        ovf, unf, chk_t;
    logic [31:0] rt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_err = 0, n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N && DONE) begin
      n_done++;
      chk("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("R", R, e.r);
        chk("OVERFLOW", {31'd0, OVERFLOW}, {31'd0, e.ovf});
        chk("UNDERFLOW", {31'd0, UNDERFLOW}, {31'd0, e.unf});
        if (e.chk_t) chk("R_trunc", R_t, e.rt);
      end
    end
  end

  task automatic push(input logic [31:0] r, input logic ovf, input logic unf,
                      input logic ct = 1'b0, input logic [31:0] rt = '0);
    exp_t x;
    x.r = r; x.ovf = ovf; x.unf = unf; x.chk_t = ct; x.rt = rt;
    sb.push_back(x);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 12 && !DONE; i++) @(negedge CLK);
    chk(tag, {31'd0, DONE}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic op,
                     input logic [31:0] r, input logic ovf, input logic unf,
                     input logic ct = 1'b0, input logic [31:0] rt = '0);
    push(r, ovf, unf, ct, rt);
    A = a; B = b; OP = op; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; A = $urandom; B = $urandom; OP = 1'($urandom);
    wait_done("done_seen");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) @(negedge CLK);
    chk("rst_R", R, 32'd0);
    chk("rst_BUSY", {31'd0, BUSY}, 32'd0);
    chk("rst_DONE", {31'd0, DONE}, 32'd0);
    chk("rst_flags", {30'd0, OVERFLOW, UNDERFLOW}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Latency/handshake: START in cycle 0, BUSY 1..5, DONE 6.
    push(32'h4000_0000, 1'b0, 1'b0);
    A = 32'h3F80_0000; B = 32'h3F80_0000; OP = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("busy_c%0d", c), {31'd0, BUSY}, {31'd0, c <= 5});
      chk($sformatf("done_c%0d", c), {31'd0, DONE}, {31'd0, c == 6});
      if (c < 6) @(negedge CLK);
    end

    // Back-to-back from the DONE cycle.
    run(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run(32'hC040_0000, 32'h3F80_0000, 1'b0, 32'hC000_0000, 1'b0, 1'b0);
    run(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    run(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    run(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 1'b1, 32'h3F80_0000);
    run(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b0, 1'b1, 32'h3F80_0001);
    run(32'h3FC0_0000, 32'h4020_0000, 1'b0, 32'h4080_0000, 1'b0, 1'b0);
    run(32'h3F80_0000, 32'h3F00_0000, 1'b1, 32'h3F00_0000, 1'b0, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    run(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    run(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run(32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    run(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    run(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1'b0);
    run(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0);
    run(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0);

    // START during a busy operation is dropped.
    @(negedge CLK);
    d0 = n_done;
    push(32'hC000_0000, 1'b0, 1'b0);
    A = 32'hC040_0000; B = 32'h3F80_0000; OP = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    A = 32'h4000_0000; B = 32'h4000_0000; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("done_busy_start");
    repeat (10) @(negedge CLK);
    #1;
    chk("one_done", n_done, d0 + 1);

    // Overflow result in place, then reset mid-operation.
    run(32'hFF7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'hFF80_0000, 1'b1, 1'b0);
    @(negedge CLK);
    d0 = n_done;
    A = 32'h3F80_0000; B = 32'h3F80_0000; OP = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("midrst_R", R, 32'd0);
    chk("midrst_flags", {30'd0, OVERFLOW, UNDERFLOW}, 32'd0);
    chk("midrst_BUSY", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    chk("midrst_no_done", n_done, d0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
